bcd_chain_counter: RTL

//  Parametrised multi-digit base-N counter for the stopwatch datapath; next generation of the single-counter wrapper.

---
 rtl/bcd_chain_counter.sv | 112 +++++++++++
 1 files changed

// File: rtl/bcd_chain_counter.sv
// Multi-digit base-N up/down counter with synchronous load, programmable terminal
// value, wrap or saturate at terminal, registered terminal pulse and at-limit flag.
module bcd_chain_counter #(
  parameter int BASE             = 10,
  parameter int NUMBER_OF_NYBLES = 4,
  parameter int SATURATE         = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          up_down,
  input  logic                          load,
  input  logic [4*NUMBER_OF_NYBLES-1:0] numberIn,
  input  logic [4*NUMBER_OF_NYBLES-1:0] limit,
  output logic [4*NUMBER_OF_NYBLES-1:0] numberOut,
  output logic                          threshold,
  output logic                          at_limit
);

  localparam int W = 4 * NUMBER_OF_NYBLES;
  localparam logic [3:0] MAX_DIGIT = 4'(BASE - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] load_clamped, limit_clamped;
  logic [W-1:0] cnt_inc, cnt_dec;
  logic         thr_q, thr_d;
  logic         at_lim_q, at_lim_d;
  logic         carry, borrow;

  always_comb begin
    load_clamped  = '0;
    limit_clamped = '0;
    for (int unsigned i = 0; i < NUMBER_OF_NYBLES; i++) begin
      load_clamped[4*i +: 4]  = (numberIn[4*i +: 4] > MAX_DIGIT) ? MAX_DIGIT : numberIn[4*i +: 4];
      limit_clamped[4*i +: 4] = (limit[4*i +: 4] > MAX_DIGIT) ? MAX_DIGIT : limit[4*i +: 4];
    end
  end

  // Ripple carry/borrow across digits; a digit only moves while all lower digits roll.
  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int unsigned i = 0; i < NUMBER_OF_NYBLES; i++) begin
      if (carry) begin
        if (cnt_q[4*i +: 4] == MAX_DIGIT) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end else begin
        cnt_inc[4*i +: 4] = cnt_q[4*i +: 4];
      end
      if (borrow) begin
        if (cnt_q[4*i +: 4] == 4'd0) begin
          cnt_dec[4*i +: 4] = MAX_DIGIT;
        end else begin
          cnt_dec[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end else begin
        cnt_dec[4*i +: 4] = cnt_q[4*i +: 4];
      end
    end
  end

  // Packed 4-bit digit fields compare numerically MSB-first, so a plain
  // vector compare gives the digit-wise ordering.
  always_comb begin
    cnt_d = cnt_q;
    thr_d = 1'b0;
    if (load) begin
      cnt_d = load_clamped;
    end else if (enable) begin
      if (up_down) begin
        if (cnt_q >= limit_clamped) begin
          thr_d = 1'b1;
          cnt_d = (SATURATE != 0) ? cnt_q : '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        if (cnt_q == '0) begin
          thr_d = 1'b1;
          cnt_d = (SATURATE != 0) ? '0 : limit_clamped;
        end else begin
          cnt_d = cnt_dec;
        end
      end
    end
    at_lim_d = (cnt_d == limit_clamped);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      thr_q    <= 1'b0;
      at_lim_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      thr_q    <= thr_d;
      at_lim_q <= at_lim_d;
    end
  end

  assign numberOut = cnt_q;
  assign threshold = thr_q;
  assign at_limit  = at_lim_q;

endmodule
